// File: rtl/trap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : trap_sequencer                                               |
// | Description : Machine-mode trap entry / mret sequencer driving a CSR file  |
// |               through a single shared address/data port.                   |
// |               Optional feature macro: TRAP_VECTORED_EN (vectored mtvec).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module trap_sequencer #(
    parameter logic [63:0] MTVEC_RESET = 64'h0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        TRAP_REQ,
    input  logic [63:0] TRAP_CAUSE,
    input  logic [63:0] EPC_IN,
    input  logic        RET_REQ,
    input  logic [63:0] CSR_RDATA,
    output logic [11:0] CSR_ADDR,
    output logic [63:0] CSR_WDATA,
    output logic        CSR_WE,
    output logic        BUSY,
    output logic        DONE,
    output logic [63:0] NEW_PC,
    output logic [1:0]  PRIV
);

    localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] c_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;
    localparam logic [63:0] c_CAUSE_ILLEGAL = 64'd2;
    localparam logic [1:0]  c_PRIV_M = 2'b11;
    localparam logic [1:0]  c_PRIV_U = 2'b00;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_T_CAUSE  = 3'd1;
    localparam logic [2:0] c_T_EPC    = 3'd2;
    localparam logic [2:0] c_T_STATUS = 3'd3;
    localparam logic [2:0] c_T_VEC    = 3'd4;
    localparam logic [2:0] c_R_STATUS = 3'd5;
    localparam logic [2:0] c_R_EPC    = 3'd6;
    localparam logic [2:0] c_FIN      = 3'd7;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [63:0] r_cause;
    logic [63:0] r_epc;
    logic [63:0] r_new_pc;
    logic [1:0]  r_priv;
    logic [1:0]  r_ret_priv;
    logic [63:0] w_base;
    logic [63:0] w_target;
    logic [63:0] w_status_trap;
    logic [63:0] w_status_ret;
    logic [1:0]  w_ret_priv;
    logic        w_unused;

    assign w_base = {CSR_RDATA[63:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign w_target = (CSR_RDATA[1:0] == 2'b01 && r_cause[63])
                    ? w_base + {50'd0, r_cause[11:0], 2'b00}
                    : w_base;
`else
    assign w_target = w_base;
`endif

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- current privilege
    always_comb begin
        w_status_trap        = CSR_RDATA;
        w_status_trap[7]     = CSR_RDATA[3];
        w_status_trap[3]     = 1'b0;
        w_status_trap[12:11] = r_priv;
    end

    // mret: MIE <- MPIE, MPIE <- 1, MPP <- U; unsupported S/H modes fall back to U
    always_comb begin
        w_status_ret        = CSR_RDATA;
        w_status_ret[3]     = CSR_RDATA[7];
        w_status_ret[7]     = 1'b1;
        w_status_ret[12:11] = c_PRIV_U;
        w_ret_priv = (CSR_RDATA[12:11] == c_PRIV_M) ? c_PRIV_M : c_PRIV_U;
    end

    assign w_unused = ^{MTVEC_RESET, CSR_RDATA[1:0]};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= c_IDLE;
            r_cause    <= 64'd0;
            r_epc      <= 64'd0;
            r_new_pc   <= 64'd0;
            r_priv     <= c_PRIV_M;
            r_ret_priv <= c_PRIV_U;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_IDLE: begin
                    if (TRAP_REQ) begin
                        r_cause <= TRAP_CAUSE;
                        r_epc   <= EPC_IN;
                    end else if (RET_REQ && r_priv != c_PRIV_M) begin
                        r_cause <= c_CAUSE_ILLEGAL;
                        r_epc   <= EPC_IN;
                    end
                end
                c_T_VEC: begin
                    r_new_pc <= w_target;
                    r_priv   <= c_PRIV_M;
                end
                c_R_STATUS: r_ret_priv <= w_ret_priv;
                c_R_EPC: begin
                    r_new_pc <= w_base;
                    r_priv   <= r_ret_priv;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        CSR_ADDR     = 12'd0;
        CSR_WDATA    = 64'd0;
        CSR_WE       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (TRAP_REQ)
                    w_next_state = c_T_CAUSE;
                else if (RET_REQ)
                    w_next_state = (r_priv == c_PRIV_M) ? c_R_STATUS : c_T_CAUSE;
            end
            c_T_CAUSE: begin
                CSR_ADDR     = c_ADDR_MCAUSE;
                CSR_WDATA    = r_cause;
                CSR_WE       = 1'b1;
                w_next_state = c_T_EPC;
            end
            c_T_EPC: begin
                CSR_ADDR     = c_ADDR_MEPC;
                CSR_WDATA    = r_epc;
                CSR_WE       = 1'b1;
                w_next_state = c_T_STATUS;
            end
            c_T_STATUS: begin
                CSR_ADDR     = c_ADDR_MSTATUS;
                CSR_WDATA    = w_status_trap;
                CSR_WE       = 1'b1;
                w_next_state = c_T_VEC;
            end
            c_T_VEC: begin
                CSR_ADDR     = c_ADDR_MTVEC;
                w_next_state = c_FIN;
            end
            c_R_STATUS: begin
                CSR_ADDR     = c_ADDR_MSTATUS;
                CSR_WDATA    = w_status_ret;
                CSR_WE       = 1'b1;
                w_next_state = c_R_EPC;
            end
            c_R_EPC: begin
                CSR_ADDR     = c_ADDR_MEPC;
                w_next_state = c_FIN;
            end
            c_FIN: w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    assign BUSY   = (r_state != c_IDLE);
    assign DONE   = (r_state == c_FIN);
    assign NEW_PC = r_new_pc;
    assign PRIV   = r_priv;

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_trap_sequencer                                            |
// | Description : Scoreboard bench for trap_sequencer with a CSR file model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_trap_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        TRAP_REQ = 1'b0;
    logic [63:0] TRAP_CAUSE = 64'd0;
    logic [63:0] EPC_IN = 64'd0;
    logic        RET_REQ = 1'b0;
    logic [63:0] CSR_RDATA;
    logic [11:0] CSR_ADDR;
    logic [63:0] CSR_WDATA;
    logic        CSR_WE;
    logic        BUSY;
    logic        DONE;
    logic [63:0] NEW_PC;
    logic [1:0]  PRIV;

    trap_sequencer #(.MTVEC_RESET(64'h0)) dut (
        .CLK(CLK), .RESET(RESET), .TRAP_REQ(TRAP_REQ), .TRAP_CAUSE(TRAP_CAUSE),
        .EPC_IN(EPC_IN), .RET_REQ(RET_REQ), .CSR_RDATA(CSR_RDATA),
        .CSR_ADDR(CSR_ADDR), .CSR_WDATA(CSR_WDATA), .CSR_WE(CSR_WE),
        .BUSY(BUSY), .DONE(DONE), .NEW_PC(NEW_PC), .PRIV(PRIV)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // CSR file seen by the DUT; preloads go through the same process as DUT writes
    logic [63:0] mem_status, mem_tvec, mem_epc, mem_cause;
    logic        pre_we = 1'b0;
    logic [11:0] pre_addr = 12'd0;
    logic [63:0] pre_data = 64'd0;

    always @(posedge CLK) begin
        if (CSR_WE) begin
            case (CSR_ADDR)
                12'h300: mem_status <= CSR_WDATA;
                12'h305: mem_tvec   <= CSR_WDATA;
                12'h341: mem_epc    <= CSR_WDATA;
                12'h342: mem_cause  <= CSR_WDATA;
                default: ;
            endcase
        end else if (pre_we) begin
            case (pre_addr)
                12'h300: mem_status <= pre_data;
                12'h305: mem_tvec   <= pre_data;
                12'h341: mem_epc    <= pre_data;
                12'h342: mem_cause  <= pre_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        CSR_RDATA = 64'd0;
        case (CSR_ADDR)
            12'h300: CSR_RDATA = mem_status;
            12'h305: CSR_RDATA = mem_tvec;
            12'h341: CSR_RDATA = mem_epc;
            12'h342: CSR_RDATA = mem_cause;
            default: CSR_RDATA = 64'd0;
        endcase
    end

    typedef struct {
        bit          is_done;
        logic [11:0] addr;
        logic [63:0] data;
        logic [1:0]  priv;
        int          cyc;
    } ev_t;
    ev_t q[$];

    // Architectural reference state
    logic [63:0] m_mstatus = 64'd0, m_mtvec = 64'd0, m_mepc = 64'd0, m_mcause = 64'd0;
    logic [1:0]  m_priv = 2'b11;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %h (t=%0t)", name, act, $time);
    endtask

    task automatic push_write(input logic [11:0] a, input logic [63:0] d);
        ev_t e;
        e.is_done = 1'b0; e.addr = a; e.data = d; e.priv = 2'b00; e.cyc = 0;
        q.push_back(e);
    endtask

    task automatic push_done(input logic [63:0] pc, input logic [1:0] p, input int c);
        ev_t e;
        e.is_done = 1'b1; e.addr = 12'd0; e.data = pc; e.priv = p; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic model_trap(input logic [63:0] cause, input logic [63:0] epc, input int c);
        logic [63:0] st;
        logic [63:0] tgt;
        push_write(12'h342, cause);
        push_write(12'h341, epc);
        st = m_mstatus;
        st[7] = m_mstatus[3];
        st[3] = 1'b0;
        st[12:11] = m_priv;
        push_write(12'h300, st);
        m_mcause = cause; m_mepc = epc; m_mstatus = st;
        tgt = m_mtvec & ~64'd3;
`ifdef TRAP_VECTORED_EN
        if (m_mtvec[1:0] == 2'b01 && cause[63]) tgt = tgt + 64'(cause[11:0]) * 64'd4;
`endif
        m_priv = 2'b11;
        push_done(tgt, 2'b11, c + 5);
    endtask

    task automatic model_ret(input logic [63:0] epc, input int c);
        logic [63:0] st;
        logic [1:0]  mpp;
        if (m_priv != 2'b11) begin
            model_trap(64'd2, epc, c);
        end else begin
            st = m_mstatus;
            mpp = m_mstatus[12:11];
            st[3] = m_mstatus[7];
            st[7] = 1'b1;
            st[12:11] = 2'b00;
            push_write(12'h300, st);
            m_mstatus = st;
            m_priv = (mpp == 2'b11) ? 2'b11 : 2'b00;
            push_done(m_mepc & ~64'd3, m_priv, c + 3);
        end
    endtask

    always @(negedge CLK) begin
        ev_t e;
        if (!RESET) begin
            if (CSR_WE) begin
                if (q.size() == 0) fail_now("unexpected_write", 64'(CSR_ADDR));
                else begin
                    e = q.pop_front();
                    if (e.is_done) fail_now("write_instead_of_done", 64'(CSR_ADDR));
                    else begin
                        check64("csr_addr", 64'(CSR_ADDR), 64'(e.addr));
                        check64("csr_wdata", CSR_WDATA, e.data);
                    end
                end
            end
            if (DONE) begin
                if (q.size() == 0) fail_now("unexpected_done", NEW_PC);
                else begin
                    e = q.pop_front();
                    if (!e.is_done) fail_now("done_instead_of_write", 64'(e.addr));
                    else begin
                        check64("new_pc", NEW_PC, e.data);
                        check64("priv", 64'(PRIV), 64'(e.priv));
                        check64("done_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
            if (!BUSY) begin
                check64("idle_we_addr", {51'd0, CSR_WE, CSR_ADDR}, 64'd0);
                check64("idle_wdata", CSR_WDATA, 64'd0);
            end
        end
    end

    task automatic set_csr(input logic [11:0] a, input logic [63:0] d);
        @(negedge CLK);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge CLK);
        #1 pre_we = 1'b0;
        case (a)
            12'h300: m_mstatus = d;
            12'h305: m_mtvec   = d;
            12'h341: m_mepc    = d;
            default: m_mcause  = d;
        endcase
    endtask

    task automatic issue(input bit t, input bit r, input logic [63:0] cause,
                         input logic [63:0] epc, input bit pulse);
        int n;
        @(negedge CLK);
        TRAP_REQ = t; RET_REQ = r; TRAP_CAUSE = cause; EPC_IN = epc;
        if (t) model_trap(cause, epc, cyc);
        else   model_ret(epc, cyc);
        if (pulse) begin
            @(negedge CLK); TRAP_REQ = 1'b0; RET_REQ = 1'b0;
            @(negedge CLK); TRAP_REQ = 1'b1; TRAP_CAUSE = ~cause;
            @(negedge CLK); TRAP_REQ = 1'b0;
        end
        n = 0;
        while (!DONE && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) fail_now("done_timeout", 64'(n));
        TRAP_REQ = 1'b0; RET_REQ = 1'b0;
    endtask

    initial begin
        @(posedge CLK);
        #1;
        check64("rst_busy_done", {62'd0, BUSY, DONE}, 64'd0);
        check64("rst_priv", 64'(PRIV), 64'd3);
        check64("rst_new_pc", NEW_PC, 64'd0);
        check64("rst_csr_port", {51'd0, CSR_WE, CSR_ADDR}, 64'd0);
        check64("rst_wdata", CSR_WDATA, 64'd0);
        set_csr(12'h342, 64'd0);
        set_csr(12'h300, 64'h1880);
        set_csr(12'h341, 64'h2002);
        set_csr(12'h305, 64'h4001);
        @(posedge CLK);
        #2 RESET = 1'b0;

        issue(1'b0, 1'b1, 64'd0, 64'h10, 1'b0);                   // mret to M
        check64("ret_mstatus", mem_status, 64'h88);
        set_csr(12'h300, 64'd0);
        issue(1'b0, 1'b1, 64'd0, 64'h10, 1'b0);                   // mret to U
        set_csr(12'h300, 64'h8);
        issue(1'b1, 1'b0, 64'h8, 64'h1000, 1'b0);                 // trap from U
        check64("trap_mstatus", mem_status, 64'h80);
        set_csr(12'h300, 64'h800);
        issue(1'b0, 1'b1, 64'd0, 64'h10, 1'b0);                   // MPP=01 maps to U
        issue(1'b0, 1'b1, 64'd0, 64'h5000, 1'b0);                 // illegal mret from U
        check64("illegal_mcause", mem_cause, 64'd2);
        issue(1'b1, 1'b0, 64'h8000_0000_0000_0007, 64'h6000, 1'b0);
        issue(1'b1, 1'b1, 64'hB, 64'h7000, 1'b0);                 // trap wins
        issue(1'b1, 1'b0, 64'h3, 64'h7100, 1'b1);                 // pulse while busy

        // Reset landing in T_STATUS: mcause/mepc committed, mstatus untouched
        @(negedge CLK);
        TRAP_REQ = 1'b1; TRAP_CAUSE = 64'hB; EPC_IN = 64'h8000;
        push_write(12'h342, 64'hB);
        push_write(12'h341, 64'h8000);
        m_mcause = 64'hB; m_mepc = 64'h8000;
        @(posedge CLK);
        @(negedge CLK); TRAP_REQ = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        check64("abort_busy_done", {62'd0, BUSY, DONE}, 64'd0);
        check64("abort_priv", 64'(PRIV), 64'd3);
        check64("abort_new_pc", NEW_PC, 64'd0);
        check64("abort_we", 64'(CSR_WE), 64'd0);
        m_priv = 2'b11;
        @(posedge CLK);
        #1;
        check64("abort_mstatus", mem_status, m_mstatus);
        check64("abort_mcause", mem_cause, m_mcause);
        check64("abort_mepc", mem_epc, m_mepc);
        check64("abort_queue", 64'(q.size()), 64'd0);
        @(posedge CLK);
        #2 RESET = 1'b0;
        issue(1'b1, 1'b0, 64'h5, 64'h9000, 1'b0);                 // first edge after reset

        for (int i = 0; i < 60; i++) begin
            logic [63:0] cause;
            logic [63:0] epc;
            int op;
            if ($urandom_range(0, 2) == 0) set_csr(12'h300, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) set_csr(12'h341, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0)
                set_csr(12'h305, {$urandom, $urandom} & ~64'd3 | 64'($urandom_range(0, 3)));
            cause = {$urandom, $urandom};
            epc = {$urandom, $urandom};
            op = $urandom_range(0, 2);
            issue(op != 1, op != 0, cause, epc, $urandom_range(0, 3) == 0);
        end

        repeat (4) @(negedge CLK);
        check64("queue_empty", 64'(q.size()), 64'd0);
        check64("final_mstatus", mem_status, m_mstatus);
        check64("final_mepc", mem_epc, m_mepc);
        check64("final_priv", 64'(PRIV), 64'(m_priv));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
